// File: rtl/fc_mem_port_ctrl.sv
// Port controller for the FC memory: sequences external region loads and
// compute runs, owning the memory write port and the region select.
module fc_mem_port_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int NUM_LAYERS = 2,
  parameter int REG_W      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic [REG_W-1:0]  load_region,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              start,
  input  logic              eng_we,
  input  logic [DATA_W-1:0] eng_data,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              layer_end,
  input  logic              eng_all_end,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [REG_W-1:0]  region_sel,
  output logic              busy,
  output logic              load_done,
  output logic              run_done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [REG_W-1:0] LAST_REGION = REG_W'(NUM_LAYERS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [ADDR_W-1:0] len_q, len_nxt;
  logic [ADDR_W-1:0] count_q, count_nxt;
  logic [REG_W-1:0]  layer_q, layer_nxt, layer_eff;
  logic [REG_W-1:0]  region_nxt;
  logic              mem_we_nxt, load_done_nxt, run_done_nxt, err_nxt;
  logic [DATA_W-1:0] mem_data_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  assign ex_ready = (state == LOAD);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      layer_q    <= '0;
      region_sel <= '0;
      mem_we     <= 1'b0;
      mem_data   <= '0;
      mem_addr   <= '0;
      load_done  <= 1'b0;
      run_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      base_q     <= base_nxt;
      len_q      <= len_nxt;
      count_q    <= count_nxt;
      layer_q    <= layer_nxt;
      region_sel <= region_nxt;
      mem_we     <= mem_we_nxt;
      mem_data   <= mem_data_nxt;
      mem_addr   <= mem_addr_nxt;
      load_done  <= load_done_nxt;
      run_done   <= run_done_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    base_nxt      = base_q;
    len_nxt       = len_q;
    count_nxt     = count_q;
    layer_nxt     = layer_q;
    layer_eff     = layer_q;
    region_nxt    = region_sel;
    mem_we_nxt    = 1'b0;
    mem_data_nxt  = mem_data;
    mem_addr_nxt  = mem_addr;
    load_done_nxt = 1'b0;
    run_done_nxt  = 1'b0;
    err_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        // A load request always takes priority over a coincident start.
        if (load_req) begin
          if (load_region > LAST_REGION) begin
            err_nxt = 1'b1;
          end else if (load_len == '0) begin
            load_done_nxt = 1'b1;
          end else begin
            state_nxt  = LOAD;
            base_nxt   = load_base;
            len_nxt    = load_len;
            count_nxt  = '0;
            region_nxt = load_region;
          end
        end else if (start) begin
          state_nxt  = RUN;
          region_nxt = '0;
          layer_nxt  = '0;
        end
      end

      LOAD: begin
        if (start) err_nxt = 1'b1;
        if (ex_valid) begin
          mem_we_nxt   = 1'b1;
          mem_data_nxt = ex_data;
          mem_addr_nxt = base_q + count_q;
          count_nxt    = count_q + ADDR_W'(1);
          if (count_q == len_q - ADDR_W'(1)) begin
            state_nxt     = IDLE;
            load_done_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        mem_we_nxt   = eng_we;
        mem_data_nxt = eng_data;
        mem_addr_nxt = eng_addr;
        if (start) err_nxt = 1'b1;
        if (layer_end) begin
          if (layer_q == LAST_REGION) begin
            err_nxt = 1'b1;
          end else begin
            layer_eff  = layer_q + REG_W'(1);
            region_nxt = region_sel + REG_W'(1);
          end
        end
        layer_nxt = layer_eff;
        // The run ends on eng_all_end regardless; leave the output region selected.
        if (eng_all_end) begin
          state_nxt    = IDLE;
          run_done_nxt = 1'b1;
          region_nxt   = LAST_REGION;
          if (layer_eff != LAST_REGION) err_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fc_mem_port_ctrl.sv
// Directed bench for fc_mem_port_ctrl: per-cycle vector table plus
// hand-written burst-load and run sequences.
module tb_fc_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_req;
  logic [1:0]  load_region;
  logic [15:0] load_base, load_len;
  logic        ex_valid;
  logic [15:0] ex_data;
  logic        ex_ready;
  logic        start;
  logic        eng_we;
  logic [15:0] eng_data, eng_addr;
  logic        layer_end, eng_all_end;
  logic        mem_we;
  logic [15:0] mem_data, mem_addr;
  logic [1:0]  region_sel;
  logic        busy, load_done, run_done, err;

  int checks   = 0;
  int failures = 0;

  fc_mem_port_ctrl #(.DATA_W(16), .ADDR_W(16), .NUM_LAYERS(2), .REG_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_req(load_req), .load_region(load_region), .load_base(load_base), .load_len(load_len),
    .ex_valid(ex_valid), .ex_data(ex_data), .ex_ready(ex_ready),
    .start(start), .eng_we(eng_we), .eng_data(eng_data), .eng_addr(eng_addr),
    .layer_end(layer_end), .eng_all_end(eng_all_end),
    .mem_we(mem_we), .mem_data(mem_data), .mem_addr(mem_addr),
    .region_sel(region_sel), .busy(busy),
    .load_done(load_done), .run_done(run_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        load_req;
    logic [1:0]  region;
    logic [15:0] base, len;
    logic        ex_valid;
    logic [15:0] ex_data;
    logic        start, eng_we;
    logic [15:0] eng_data, eng_addr;
    logic        layer_end, all_end;
  } stim_t;

  typedef struct {
    logic        we;
    logic [15:0] data, addr;
    logic [1:0]  rs;
    logic        busy, rdy, ld, rd, er;
    logic        full;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];

  function automatic stim_t s_idle();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_ld(logic [1:0] r, logic [15:0] b, logic [15:0] l);
    stim_t s = s_idle();
    s.load_req = 1'b1; s.region = r; s.base = b; s.len = l;
    return s;
  endfunction

  function automatic stim_t s_ex(logic v, logic [15:0] d);
    stim_t s = s_idle();
    s.ex_valid = v; s.ex_data = d;
    return s;
  endfunction

  function automatic stim_t s_eng(logic we, logic [15:0] d, logic [15:0] a, logic le, logic ae);
    stim_t s = s_idle();
    s.eng_we = we; s.eng_data = d; s.eng_addr = a; s.layer_end = le; s.all_end = ae;
    return s;
  endfunction

  function automatic stim_t s_st();
    stim_t s = s_idle();
    s.start = 1'b1;
    return s;
  endfunction

  function automatic exp_t o(logic we, logic [15:0] d, logic [15:0] a, logic [1:0] rs,
                             logic bz, logic rdy, logic ld, logic rd, logic er);
    exp_t e;
    e.we = we; e.data = d; e.addr = a; e.rs = rs; e.busy = bz; e.rdy = rdy;
    e.ld = ld; e.rd = rd; e.er = er; e.full = 1'b0;
    return e;
  endfunction

  function automatic exp_t o_zero();
    exp_t e = o(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 0);
    e.full = 1'b1;
    return e;
  endfunction

  function automatic void add(stim_t s, exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    reset_n     = s.rst_n;
    load_req    = s.load_req;
    load_region = s.region;
    load_base   = s.base;
    load_len    = s.len;
    ex_valid    = s.ex_valid;
    ex_data     = s.ex_data;
    start       = s.start;
    eng_we      = s.eng_we;
    eng_data    = s.eng_data;
    eng_addr    = s.eng_addr;
    layer_end   = s.layer_end;
    eng_all_end = s.all_end;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  stim_t t;
  exp_t  x;
  logic  seen;

  initial begin
    applyStimulus(s_idle());
    reset_n = 1'b0;
    #2;

    // reset and idle
    t = s_idle(); t.rst_n = 1'b0;
    add(t, o_zero());
    add(s_idle(), o_zero());
    // contiguous load across the 0x00FF/0x0100 boundary
    add(s_ld(2'd1, 16'h00FE, 16'd4), o(0, 0, 0, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00A0), o(1, 16'h00A0, 16'h00FE, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00A1), o(1, 16'h00A1, 16'h00FF, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00A2), o(1, 16'h00A2, 16'h0100, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00A3), o(1, 16'h00A3, 16'h0101, 2'd1, 0, 0, 1, 0, 0));
    add(s_idle(), o(0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    // load with bubbles
    add(s_ld(2'd2, 16'h00FE, 16'd4), o(0, 0, 0, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00B0), o(1, 16'h00B0, 16'h00FE, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(0, 16'h0000), o(0, 0, 0, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00B1), o(1, 16'h00B1, 16'h00FF, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(0, 16'h0000), o(0, 0, 0, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00B2), o(1, 16'h00B2, 16'h0100, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(0, 16'h0000), o(0, 0, 0, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00B3), o(1, 16'h00B3, 16'h0101, 2'd2, 0, 0, 1, 0, 0));
    add(s_idle(), o(0, 0, 0, 2'd2, 0, 0, 0, 0, 0));
    // address wrap
    add(s_ld(2'd0, 16'hFFFF, 16'd2), o(0, 0, 0, 2'd0, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00C0), o(1, 16'h00C0, 16'hFFFF, 2'd0, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00C1), o(1, 16'h00C1, 16'h0000, 2'd0, 0, 0, 1, 0, 0));
    add(s_idle(), o(0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    // bad region, zero length
    add(s_ld(2'd3, 16'h0010, 16'd4), o(0, 0, 0, 2'd0, 0, 0, 0, 0, 1));
    add(s_idle(), o(0, 0, 0, 2'd0, 0, 0, 0, 0, 0));
    add(s_ld(2'd1, 16'h0010, 16'd0), o(0, 0, 0, 2'd0, 0, 0, 1, 0, 0));
    // load and start together, then start and engine traffic during LOAD
    t = s_ld(2'd1, 16'h0020, 16'd2); t.start = 1'b1;
    add(t, o(0, 0, 0, 2'd1, 1, 1, 0, 0, 0));
    t = s_ex(1, 16'h00D0); t.start = 1'b1;
    add(t, o(1, 16'h00D0, 16'h0020, 2'd1, 1, 1, 0, 0, 1));
    t = s_ex(1, 16'h00D1); t.eng_we = 1'b1; t.eng_data = 16'h0055; t.eng_addr = 16'h0099;
    add(t, o(1, 16'h00D1, 16'h0021, 2'd1, 0, 0, 1, 0, 0));
    add(s_idle(), o(0, 0, 0, 2'd1, 0, 0, 0, 0, 0));
    // full run with engine write
    add(s_st(), o(0, 0, 0, 2'd0, 1, 0, 0, 0, 0));
    add(s_eng(1, 16'h0012, 16'h0005, 0, 0), o(1, 16'h0012, 16'h0005, 2'd0, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 0), o(0, 0, 0, 2'd1, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 0), o(0, 0, 0, 2'd2, 1, 0, 0, 0, 0));
    add(s_st(), o(0, 0, 0, 2'd2, 1, 0, 0, 0, 1));
    add(s_ld(2'd0, 16'h0000, 16'd4), o(0, 0, 0, 2'd2, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 0), o(0, 0, 0, 2'd2, 1, 0, 0, 0, 1));
    add(s_eng(0, 16'h0000, 16'h0000, 0, 1), o(0, 0, 0, 2'd2, 0, 0, 0, 1, 0));
    add(s_idle(), o(0, 0, 0, 2'd2, 0, 0, 0, 0, 0));
    // run ended early after one layer
    add(s_st(), o(0, 0, 0, 2'd0, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 0), o(0, 0, 0, 2'd1, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 0, 1), o(0, 0, 0, 2'd2, 0, 0, 0, 1, 1));
    add(s_idle(), o(0, 0, 0, 2'd2, 0, 0, 0, 0, 0));
    // final layer_end coincident with eng_all_end
    add(s_st(), o(0, 0, 0, 2'd0, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 0), o(0, 0, 0, 2'd1, 1, 0, 0, 0, 0));
    add(s_eng(0, 16'h0000, 16'h0000, 1, 1), o(0, 0, 0, 2'd2, 0, 0, 0, 1, 0));
    // reset in the middle of a load, then a fresh load
    add(s_ld(2'd1, 16'h0040, 16'd8), o(0, 0, 0, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00E0), o(1, 16'h00E0, 16'h0040, 2'd1, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00E1), o(1, 16'h00E1, 16'h0041, 2'd1, 1, 1, 0, 0, 0));
    t = s_ex(1, 16'h00E2); t.rst_n = 1'b0;
    add(t, o_zero());
    add(s_idle(), o_zero());
    add(s_ld(2'd2, 16'h0080, 16'd2), o(0, 0, 0, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00F0), o(1, 16'h00F0, 16'h0080, 2'd2, 1, 1, 0, 0, 0));
    add(s_ex(1, 16'h00F1), o(1, 16'h00F1, 16'h0081, 2'd2, 0, 0, 1, 0, 0));
    add(s_idle(), o(0, 0, 0, 2'd2, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      logic [39:0] act, req;
      logic [15:0] ad, ra, ed, ea;
      applyStimulus(vecs[i].s);
      tick();
      x = vecs[i].e;
      ad = (x.we || x.full) ? mem_data : 16'h0;
      ra = (x.we || x.full) ? mem_addr : 16'h0;
      ed = (x.we || x.full) ? x.data : 16'h0;
      ea = (x.we || x.full) ? x.addr : 16'h0;
      act = {mem_we, ad, ra, region_sel, busy, ex_ready, load_done, run_done, err};
      req = {x.we, ed, ea, x.rs, x.busy, x.rdy, x.ld, x.rd, x.er};
      checkOutput($sformatf("vec%0d", i), 64'(act), 64'(req));
    end

    // sustained 8-word burst at full throughput
    applyStimulus(s_ld(2'd0, 16'h0200, 16'd8));
    tick();
    checkOutput("burst_enter", 64'({busy, ex_ready, region_sel}), 64'({1'b1, 1'b1, 2'd0}));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s_ex(1, 16'h0300 + 16'(i)));
      tick();
      checkOutput($sformatf("burst_w%0d", i),
                  64'({mem_we, mem_data, mem_addr, load_done, busy}),
                  64'({1'b1, 16'h0300 + 16'(i), 16'h0200 + 16'(i), (i == 7), (i != 7)}));
    end
    applyStimulus(s_idle());
    tick();

    // run with bounded wait for completion
    applyStimulus(s_st());
    tick();
    applyStimulus(s_eng(0, 16'h0, 16'h0, 1, 0));
    tick();
    applyStimulus(s_eng(0, 16'h0, 16'h0, 1, 0));
    tick();
    applyStimulus(s_eng(0, 16'h0, 16'h0, 0, 1));
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      applyStimulus(s_idle());
      if (run_done) begin
        seen = 1'b1;
        checkOutput("run_end_state", 64'({region_sel, busy, err}), 64'({2'd2, 1'b0, 1'b0}));
      end
    end
    checkOutput("run_done_seen", 64'(seen), 64'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
